// File: rtl/password_scan_compare_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | password_scan_compare_if                                                 |
// | Control, status and ROM/RAM read bus of the password scan comparator.    |
// | Optional mismatch_cnt signal present when PASSWORD_SCAN_FULLCOUNT_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface password_scan_compare_if #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int LEN_W     = 8,
  parameter int MAX_FAILS = 3
);
  localparam int FC_W = $clog2(MAX_FAILS + 1);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic              clear_lock;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] ram_data;
  logic              busy;
  logic              done;
  logic              match;
  logic [ADDR_W-1:0] mismatch_addr;
  logic [FC_W-1:0]   fail_count;
  logic              locked;
`ifdef PASSWORD_SCAN_FULLCOUNT_EN
  logic [LEN_W-1:0]  mismatch_cnt;
`endif

  modport slave (
    input  start, base_addr, length, clear_lock, rom_data, ram_data,
    output mem_addr, busy, done, match, mismatch_addr, fail_count, locked
`ifdef PASSWORD_SCAN_FULLCOUNT_EN
    , output mismatch_cnt
`endif
  );

  modport master (
    output start, base_addr, length, clear_lock, rom_data, ram_data,
    input  mem_addr, busy, done, match, mismatch_addr, fail_count, locked
`ifdef PASSWORD_SCAN_FULLCOUNT_EN
    , input mismatch_cnt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/password_scan_compare.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | password_scan_compare                                                    |
// | Scans an address window of the password ROM and RAM, compares words,     |
// | reports first mismatch and enforces a lockout after MAX_FAILS failures.  |
// | Optional: PASSWORD_SCAN_FULLCOUNT_EN (full scan with mismatch count).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module password_scan_compare #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int LEN_W     = 8,
  parameter int MAX_FAILS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  password_scan_compare_if.slave  bus
);
  localparam int FC_W = $clog2(MAX_FAILS + 1);
  localparam logic [FC_W-1:0] c_MAX_FAILS = FC_W'(MAX_FAILS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_DRAIN  = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t            r_state,    w_state;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
  logic [LEN_W-1:0]  r_left,     w_left;
  logic              r_rd_vld,   w_rd_vld;
  logic              r_cmp_vld,  w_cmp_vld;
  logic [ADDR_W-1:0] r_cmp_addr, w_cmp_addr;
  logic              r_busy,     w_busy;
  logic              r_done,     w_done;
  logic              r_match,    w_match;
  logic [ADDR_W-1:0] r_mm_addr,  w_mm_addr;
  logic [FC_W-1:0]   r_fail,     w_fail;
  logic              r_locked,   w_locked;
  logic              r_lock_req, w_lock_req;
  logic              w_diff;
  logic              w_fin;
  logic              w_pass;
`ifdef PASSWORD_SCAN_FULLCOUNT_EN
  logic [LEN_W-1:0]  r_err_cnt,    w_err_cnt;
  logic              r_first_seen, w_first_seen;
  logic [ADDR_W-1:0] r_first_addr, w_first_addr;
  logic [LEN_W-1:0]  r_mm_cnt,     w_mm_cnt;
  logic [LEN_W-1:0]  w_cnt_now;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mem_addr   <= '0;
      r_left       <= '0;
      r_rd_vld     <= 1'b0;
      r_cmp_vld    <= 1'b0;
      r_cmp_addr   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_match      <= 1'b0;
      r_mm_addr    <= '0;
      r_fail       <= '0;
      r_locked     <= 1'b0;
      r_lock_req   <= 1'b0;
`ifdef PASSWORD_SCAN_FULLCOUNT_EN
      r_err_cnt    <= '0;
      r_first_seen <= 1'b0;
      r_first_addr <= '0;
      r_mm_cnt     <= '0;
`endif
    end else begin
      r_state      <= w_state;
      r_mem_addr   <= w_mem_addr;
      r_left       <= w_left;
      r_rd_vld     <= w_rd_vld;
      r_cmp_vld    <= w_cmp_vld;
      r_cmp_addr   <= w_cmp_addr;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_match      <= w_match;
      r_mm_addr    <= w_mm_addr;
      r_fail       <= w_fail;
      r_locked     <= w_locked;
      r_lock_req   <= w_lock_req;
`ifdef PASSWORD_SCAN_FULLCOUNT_EN
      r_err_cnt    <= w_err_cnt;
      r_first_seen <= w_first_seen;
      r_first_addr <= w_first_addr;
      r_mm_cnt     <= w_mm_cnt;
`endif
    end
  end

  // Two-stage valid pipe: r_rd_vld = read issued last edge, r_cmp_vld = data on the bus now.
  always_comb begin
    w_state    = r_state;
    w_mem_addr = r_mem_addr;
    w_left     = r_left;
    w_rd_vld   = r_rd_vld;
    w_cmp_vld  = r_rd_vld;
    w_cmp_addr = r_mem_addr;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_match    = r_match;
    w_mm_addr  = r_mm_addr;
    w_fail     = r_fail;
    w_locked   = r_locked;
    w_lock_req = r_lock_req;
    w_fin      = 1'b0;
    w_pass     = 1'b0;
    w_diff     = r_cmp_vld && (bus.rom_data != bus.ram_data);
`ifdef PASSWORD_SCAN_FULLCOUNT_EN
    w_err_cnt    = r_err_cnt;
    w_first_seen = r_first_seen;
    w_first_addr = r_first_addr;
    w_mm_cnt     = r_mm_cnt;
    w_cnt_now    = r_err_cnt + LEN_W'(w_diff);
`endif

    case (r_state)
      S_IDLE: begin
        if (bus.clear_lock) begin
          w_fail   = '0;
          w_locked = 1'b0;
        end else if (bus.start) begin
          w_busy = 1'b1;
`ifdef PASSWORD_SCAN_FULLCOUNT_EN
          w_err_cnt    = '0;
          w_first_seen = 1'b0;
`endif
          if (bus.length == '0) begin
            w_rd_vld = 1'b0;
            w_state  = S_DRAIN;
          end else begin
            w_mem_addr = bus.base_addr;
            w_left     = bus.length - LEN_W'(1);
            w_rd_vld   = 1'b1;
            w_state    = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (r_left != '0) begin
          w_mem_addr = r_mem_addr + ADDR_W'(1);
          w_left     = r_left - LEN_W'(1);
          w_rd_vld   = 1'b1;
        end else begin
          w_rd_vld = 1'b0;
          w_state  = S_DRAIN;
        end
`ifdef PASSWORD_SCAN_FULLCOUNT_EN
        if (w_diff) begin
          w_err_cnt = w_cnt_now;
          if (!r_first_seen) begin
            w_first_seen = 1'b1;
            w_first_addr = r_cmp_addr;
          end
        end
`else
        if (w_diff) begin
          w_fin = 1'b1;
        end
`endif
      end
      S_DRAIN: begin
        // Holds the last compare; a zero-length window lands here with nothing to compare.
        w_fin = 1'b1;
`ifdef PASSWORD_SCAN_FULLCOUNT_EN
        w_pass = (w_cnt_now == '0);
`else
        w_pass = !w_diff;
`endif
      end
      S_LOCKED: begin
        if (r_lock_req) begin
          w_done     = 1'b1;
          w_match    = 1'b0;
          w_busy     = 1'b0;
          w_lock_req = 1'b0;
        end else if (bus.clear_lock) begin
          w_fail   = '0;
          w_locked = 1'b0;
          w_state  = S_IDLE;
        end else if (bus.start) begin
          w_lock_req = 1'b1;
          w_busy     = 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase

    if (w_fin) begin
      w_done    = 1'b1;
      w_busy    = 1'b0;
      w_rd_vld  = 1'b0;
      w_cmp_vld = 1'b0;
      w_match   = w_pass;
      w_state   = S_IDLE;
`ifdef PASSWORD_SCAN_FULLCOUNT_EN
      w_mm_cnt  = w_cnt_now;
`endif
      if (w_pass) begin
        w_fail = '0;
      end else begin
`ifdef PASSWORD_SCAN_FULLCOUNT_EN
        w_mm_addr = r_first_seen ? r_first_addr : r_cmp_addr;
`else
        w_mm_addr = r_cmp_addr;
`endif
        if (r_fail != c_MAX_FAILS) begin
          w_fail = r_fail + FC_W'(1);
        end
        if (w_fail == c_MAX_FAILS) begin
          w_locked = 1'b1;
          w_state  = S_LOCKED;
        end
      end
    end
  end

  assign bus.mem_addr      = r_mem_addr;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.match         = r_match;
  assign bus.mismatch_addr = r_mm_addr;
  assign bus.fail_count    = r_fail;
  assign bus.locked        = r_locked;
`ifdef PASSWORD_SCAN_FULLCOUNT_EN
  assign bus.mismatch_cnt  = r_mm_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_password_scan_compare.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_password_scan_compare                                                 |
// | Directed bench with ROM/RAM models for password_scan_compare.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_password_scan_compare;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  password_scan_compare_if #(.DATA_W(16), .ADDR_W(16), .LEN_W(8), .MAX_FAILS(3)) bus ();

  password_scan_compare #(.DATA_W(16), .ADDR_W(16), .LEN_W(8), .MAX_FAILS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [15:0] rom [65536];
  logic [15:0] ram [65536];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.rom_data <= rom[bus.mem_addr];
    bus.ram_data <= ram[bus.mem_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start so it is sampled at "edge 0"; returns just after that edge.
  task automatic launch(input logic [15:0] b, input logic [7:0] l);
    bus.base_addr = b;
    bus.length    = l;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.base_addr = 16'h0BAD;
    bus.length    = 8'd99;
  endtask

  task automatic wait_done(input int e0, output int de);
    de = -1;
    for (int e = e0; e < e0 + 400; e++) begin
      if (bus.done === 1'b1) begin
        de = e;
        break;
      end
      tick();
    end
  endtask

  function automatic int fail_edge(input int k, input int l);
`ifdef PASSWORD_SCAN_FULLCOUNT_EN
    return l + 1;
`else
    return k + 2;
`endif
  endfunction

  initial begin
    int          de;
    int          seen_done;
    logic [15:0] held_addr;
    n_tests = 0;
    n_fail  = 0;
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.length     = '0;
    bus.clear_lock = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      rom[i] = 16'(i) ^ 16'hC3A5;
      ram[i] = 16'(i) ^ 16'hC3A5;
    end
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    tick();
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_match", bus.match, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mm_addr", bus.mismatch_addr, 0);
    check("rst_fail_count", bus.fail_count, 0);
    check("rst_locked", bus.locked, 0);
`ifdef PASSWORD_SCAN_FULLCOUNT_EN
    check("rst_mm_cnt", bus.mismatch_cnt, 0);
`endif
    rst_n = 1'b1;
    tick();

    // Equal window, with a start pulse while busy that must be ignored
    launch(16'h1476, 8'd4);
    check("eq_busy_e0", bus.busy, 1);
    check("eq_addr_e0", bus.mem_addr, 16'h1476);
    bus.base_addr = 16'h5000;
    bus.length    = 8'd1;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    check("eq_addr_e1", bus.mem_addr, 16'h1477);
    check("eq_busy_e1", bus.busy, 1);
    wait_done(1, de);
    check("eq_done_edge", de, 5);
    check("eq_match", bus.match, 1);
    check("eq_fail_count", bus.fail_count, 0);
    tick();
    check("eq_done_pulse", bus.done, 0);
    check("eq_busy_after", bus.busy, 0);

    // First mismatch inside the window
    ram[16'h1478] = 16'hAAAA;
    launch(16'h1476, 8'd4);
    wait_done(0, de);
    check("mm_done_edge", de, fail_edge(2, 4));
    check("mm_match", bus.match, 0);
    check("mm_addr", bus.mismatch_addr, 16'h1478);
    check("mm_fail_count", bus.fail_count, 1);
    ram[16'h1478] = rom[16'h1478];

    // Address window wrapping through zero
    ram[16'h0000] = ~rom[16'h0000];
    launch(16'hFFFE, 8'd4);
    check("wrap_addr0", bus.mem_addr, 16'hFFFE);
    tick();
    check("wrap_addr1", bus.mem_addr, 16'hFFFF);
    tick();
    check("wrap_addr2", bus.mem_addr, 16'h0000);
    tick();
    check("wrap_addr3", bus.mem_addr, 16'h0001);
    wait_done(3, de);
    check("wrap_done_edge", de, fail_edge(2, 4));
    check("wrap_mm_addr", bus.mismatch_addr, 16'h0000);
    check("wrap_fail_count", bus.fail_count, 2);
    check("wrap_locked", bus.locked, 0);
    ram[16'h0000] = rom[16'h0000];

    // Third consecutive failure locks
    ram[16'h1476] = 16'h0000;
    launch(16'h1476, 8'd4);
    wait_done(0, de);
    check("lock_done_edge", de, fail_edge(0, 4));
    check("lock_locked", bus.locked, 1);
    check("lock_fail_count", bus.fail_count, 3);
    check("lock_mm_addr", bus.mismatch_addr, 16'h1476);
    ram[16'h1476] = rom[16'h1476];
    tick();

    // Start while locked: refused without reads
    held_addr = bus.mem_addr;
    launch(16'h2000, 8'd4);
    wait_done(0, de);
    check("lk_done_lat", (de >= 1 && de <= 2), 1);
    check("lk_match", bus.match, 0);
    check("lk_fail_count", bus.fail_count, 3);
    check("lk_mm_addr", bus.mismatch_addr, 16'h1476);
    check("lk_mem_addr", bus.mem_addr, held_addr);
    check("lk_locked", bus.locked, 1);
    tick();

    // clear_lock wins over a simultaneous start
    bus.clear_lock = 1'b1;
    bus.start      = 1'b1;
    bus.base_addr  = 16'h1476;
    bus.length     = 8'd4;
    tick();
    bus.clear_lock = 1'b0;
    bus.start      = 1'b0;
    check("clr_locked", bus.locked, 0);
    check("clr_fail_count", bus.fail_count, 0);
    check("clr_busy", bus.busy, 0);
    tick();
    check("clr_no_done", bus.done, 0);

    launch(16'h1476, 8'd4);
    wait_done(0, de);
    check("pass_done_edge", de, 5);
    check("pass_match", bus.match, 1);

    // Failure followed by a zero-length check
    ram[16'h1477] = 16'h1234;
    launch(16'h1476, 8'd2);
    wait_done(0, de);
    check("f2_done_edge", de, 3);
    check("f2_fail_count", bus.fail_count, 1);
    launch(16'h1476, 8'd0);
    wait_done(0, de);
    check("len0_done_edge", de, 1);
    check("len0_match", bus.match, 1);
    check("len0_fail_count", bus.fail_count, 0);

    // Reset in the middle of a scan
    launch(16'h1476, 8'd2);
    wait_done(0, de);
    check("pre_rst_fail_count", bus.fail_count, 1);
    tick();
    launch(16'h1476, 8'd4);
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst_busy", bus.busy, 0);
    check("mrst_mem_addr", bus.mem_addr, 0);
    check("mrst_fail_count", bus.fail_count, 0);
    check("mrst_mm_addr", bus.mismatch_addr, 0);
    #2 rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done === 1'b1) seen_done = 1;
    end
    check("mrst_no_done", seen_done, 0);
    check("mrst_idle_busy", bus.busy, 0);
    ram[16'h1477] = rom[16'h1477];

`ifdef PASSWORD_SCAN_FULLCOUNT_EN
    // Full scan counting every differing word
    ram[16'h3002] = 16'hFFFF;
    ram[16'h3005] = 16'h0000;
    launch(16'h3000, 8'd8);
    wait_done(0, de);
    check("fc_done_edge", de, 9);
    check("fc_mm_cnt", bus.mismatch_cnt, 2);
    check("fc_match", bus.match, 0);
    check("fc_mm_addr", bus.mismatch_addr, 16'h3002);
    ram[16'h3002] = rom[16'h3002];
    ram[16'h3005] = rom[16'h3005];
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
